// File: rtl/uart_receiver_pkg.sv
// Shared constants for the UART receiver: default line configuration and
// the ASCII character codes used by the surrounding codebase.
package uart_receiver_pkg;

   localparam int unsigned DEFAULT_CLOCK_FREQUENCY = 50000000;
   localparam int unsigned DEFAULT_BAUD_RATE       = 115200;

   localparam logic [7:0] ASCII_NUL   = 8'h00;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_COLON = 8'h3A;
   localparam logic [7:0] ASCII_S     = 8'h53;
   localparam logic [7:0] ASCII_U     = 8'h55;
   localparam logic [7:0] ASCII_DEL   = 8'h7F;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable
// reset value so an idle-high line does not look like activity after reset.
module sync_2ff #(
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Capture the asynchronous input through two flops to settle metastability.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         meta <= RESET_VALUE;
         q    <= RESET_VALUE;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver. The start bit is confirmed at its middle, then each
// data bit and the stop bit are sampled one bit period apart. Good frames
// raise char_ready for one clock; a low stop bit raises framing_error once
// and the receiver waits for the line to return high.
module uart_receiver
   import uart_receiver_pkg::*;
#(
   parameter int unsigned CLOCK_FREQUENCY = DEFAULT_CLOCK_FREQUENCY,
   parameter int unsigned BAUD_RATE       = DEFAULT_BAUD_RATE
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       rx,
   output logic [7:0] char_data,
   output logic       char_ready,
   output logic       framing_error
);

   localparam int unsigned BIT_PERIOD  = CLOCK_FREQUENCY / BAUD_RATE;
   localparam int unsigned HALF_PERIOD = BIT_PERIOD / 2;
   localparam int unsigned CNT_W       = $clog2(BIT_PERIOD) + 1;

   // The counter is loaded with N-1 and sampling happens when it reads zero,
   // so a sample lands exactly N clocks after the load.
   localparam logic [CNT_W-1:0] PERIOD_RELOAD = CNT_W'(BIT_PERIOD - 1);
   localparam logic [CNT_W-1:0] HALF_RELOAD   = CNT_W'(HALF_PERIOD - 1);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_START     = 3'd1;
   localparam logic [2:0] ST_DATA      = 3'd2;
   localparam logic [2:0] ST_STOP      = 3'd3;
   localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

   logic             rx_s;
   logic [2:0]       state;
   logic [CNT_W-1:0] period_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_reg;

   sync_2ff #(
      .RESET_VALUE (1'b1)
   ) u_rx_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d       (rx),
      .q       (rx_s)
   );

   // Frame FSM with bit timing, data capture and single-clock status pulses.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         period_cnt    <= '0;
         bit_idx       <= '0;
         shift_reg     <= '0;
         char_data     <= '0;
         char_ready    <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         char_ready    <= 1'b0;
         framing_error <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!rx_s) begin
                  state      <= ST_START;
                  period_cnt <= HALF_RELOAD;
               end
            end
            ST_START: begin
               if (period_cnt == '0) begin
                  if (!rx_s) begin
                     state      <= ST_DATA;
                     bit_idx    <= '0;
                     period_cnt <= PERIOD_RELOAD;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  period_cnt <= period_cnt - 1'b1;
               end
            end
            ST_DATA: begin
               if (period_cnt == '0) begin
                  shift_reg[bit_idx] <= rx_s;
                  period_cnt         <= PERIOD_RELOAD;
                  if (bit_idx == 3'd7) begin
                     state <= ST_STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  period_cnt <= period_cnt - 1'b1;
               end
            end
            ST_STOP: begin
               if (period_cnt == '0) begin
                  if (rx_s) begin
                     char_data  <= shift_reg;
                     char_ready <= 1'b1;
                     state      <= ST_IDLE;
                  end else begin
                     framing_error <= 1'b1;
                     state         <= ST_WAIT_HIGH;
                  end
               end else begin
                  period_cnt <= period_cnt - 1'b1;
               end
            end
            ST_WAIT_HIGH: begin
               if (rx_s) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver with P=16, H=8. Each frame sent pushes its
// expected event (kind, data, clock of the pulse) onto a scoreboard; a
// monitor on the falling edge pops and compares whenever a pulse appears.
module tb_uart_receiver;

   localparam int unsigned P = 16;
   localparam int unsigned H = 8;
   // Line change -> pulse observed: 2 sync flops, 1 clock to see the low
   // level in IDLE, then H + 9*P clocks to the stop sample.
   localparam int unsigned LATENCY = 2 + 1 + H + 9 * P;

   typedef struct {
      logic             is_err;
      logic [7:0]       data;
      int unsigned      cyc;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] char_data;
   logic       char_ready;
   logic       framing_error;

   int unsigned cyc = 0;
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   exp_t        sb_q[$];
   logic [7:0]  model_data = 8'h00;
   logic [7:0]  prev_data = 8'h00;

   uart_receiver #(
      .CLOCK_FREQUENCY (16),
      .BAUD_RATE       (1)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .rx            (rx),
      .char_data     (char_data),
      .char_ready    (char_ready),
      .framing_error (framing_error)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check_equal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic drive_bit(input logic v);
      rx = v;
      repeat (P) @(posedge clock);
      #1;
   endtask

   task automatic idle(input int unsigned n);
      rx = 1'b1;
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_val);
      exp_t e;
      e.cyc    = cyc + LATENCY;
      e.is_err = !stop_val;
      if (stop_val) model_data = d;
      e.data   = model_data;
      sb_q.push_back(e);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(stop_val);
   endtask

   // Monitor: score every pulse and watch the hold/exclusivity rules.
   always @(negedge clock) begin
      if (reset_n) begin
         if (char_ready && framing_error)
            check_equal("ready_err_exclusive", 32'd1, 32'd0);
         if (char_ready || framing_error) begin
            if (sb_q.size() == 0) begin
               check_equal("unexpected_pulse", {30'd0, framing_error, char_ready}, 32'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check_equal("event_kind", 32'(framing_error), 32'(e.is_err));
               check_equal("event_data", 32'(char_data), 32'(e.data));
               check_equal("event_cycle", cyc, e.cyc);
            end
         end
         if (!char_ready && char_data !== prev_data)
            check_equal("data_hold", 32'(char_data), 32'(prev_data));
      end
      prev_data = char_data;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, pending=%0d", sb_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clock);
      check_equal("reset_char_data", 32'(char_data), 32'h00);
      check_equal("reset_char_ready", 32'(char_ready), 32'd0);
      check_equal("reset_framing_error", 32'(framing_error), 32'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      idle(10);

      // Single good frame
      send_frame(8'h55, 1'b1);
      idle(20);

      // Back-to-back frames, no gap beyond the stop bit
      send_frame(8'hA3, 1'b1);
      send_frame(8'h0D, 1'b1);
      idle(20);

      // Short glitch is rejected, then a normal frame
      rx = 1'b0;
      repeat (4) @(posedge clock); #1;
      idle(40);
      check_equal("glitch_no_event_pending", sb_q.size(), 32'd0);
      send_frame(8'h53, 1'b1);
      idle(20);

      // Framing error followed by a long break
      send_frame(8'h3A, 1'b0);
      rx = 1'b0;
      repeat (500) @(posedge clock); #1;
      check_equal("break_char_data_kept", 32'(char_data), 32'h53);
      idle(20);
      send_frame(8'h0A, 1'b1);
      idle(20);

      // Reset in the middle of bit 4
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      rx = 1'b0;
      repeat (8) @(posedge clock); #1;
      reset_n = 1'b0;
      rx = 1'b1;
      #3;
      check_equal("midframe_reset_char_data", 32'(char_data), 32'h00);
      check_equal("midframe_reset_char_ready", 32'(char_ready), 32'd0);
      check_equal("midframe_reset_framing_error", 32'(framing_error), 32'd0);
      repeat (3) @(posedge clock); #1;
      reset_n = 1'b1;
      model_data = 8'h00;
      idle(200);
      check_equal("post_reset_char_data", 32'(char_data), 32'h00);
      send_frame(8'hFF, 1'b1);
      idle(20);

      check_equal("scoreboard_drained", sb_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
